// File: rtl/hdbn_enc.sv
// HDB-N line encoder: NRZ bits in, dual-rail bipolar symbols out, N+1 accepted bits of latency.
// Defining HDBN_VIOL_FLAG_EN adds the out_v / out_b marker ports for line monitors.
module hdbn_enc #(
  parameter int N = 3  // legal range 2..7; a group replaces N+1 zeros
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic data_in,
  input  logic ami_mode,
  output logic out_valid,
  output logic out_p,
  output logic out_n
`ifdef HDBN_VIOL_FLAG_EN
  ,
  output logic out_v,
  output logic out_b
`endif
);

  localparam int SW = $clog2(N + 1);
  localparam int FW = $clog2(N + 2);
  localparam logic [FW-1:0] FILL_FULL = FW'(N + 1);
  localparam logic [SW-1:0] SKIP_LOAD = SW'(N);
  localparam logic [SW-1:0] SKIP_ONE  = SW'(1);

  logic [N:0]    sr_reg, sr_next, sr_shift;
  logic [FW-1:0] fill_reg, fill_next;
  logic [SW-1:0] skip_reg, skip_next;
  logic          last_pol_reg, last_pol_next;
  logic          odd_reg, odd_next;
  logic          valid_next, p_next, n_next;
`ifdef HDBN_VIOL_FLAG_EN
  logic          v_next, b_next;
`endif

  // Window after accepting data_in: sr[0] newest, sr[N] oldest.
  assign sr_shift[0] = data_in;
  for (genvar gi = 1; gi <= N; gi++) begin : g_shift
    assign sr_shift[gi] = sr_reg[gi-1];
  end

  always_comb begin
    sr_next       = sr_reg;
    fill_next     = fill_reg;
    skip_next     = skip_reg;
    last_pol_next = last_pol_reg;
    odd_next      = odd_reg;
    valid_next    = 1'b0;
    p_next        = 1'b0;
    n_next        = 1'b0;
`ifdef HDBN_VIOL_FLAG_EN
    v_next        = 1'b0;
    b_next        = 1'b0;
`endif
    if (in_valid) begin
      sr_next = sr_shift;
      if (fill_reg != FILL_FULL) begin
        fill_next = fill_reg + FW'(1);
      end else begin
        valid_next = 1'b1;
        if (skip_reg > SKIP_ONE) begin
          skip_next = skip_reg - SKIP_ONE;
        end else if (skip_reg == SKIP_ONE) begin
          // Violation: repeats the polarity of the last non-V pulse.
          p_next    = last_pol_reg;
          n_next    = ~last_pol_reg;
          odd_next  = 1'b0;
          skip_next = '0;
`ifdef HDBN_VIOL_FLAG_EN
          v_next    = 1'b1;
`endif
        end else if (sr_reg[N]) begin
          p_next        = ~last_pol_reg;
          n_next        = last_pol_reg;
          last_pol_next = ~last_pol_reg;
          odd_next      = ~odd_reg;
        end else if (!ami_mode && (sr_reg == '0)) begin
          skip_next = SKIP_LOAD;
          // Even pulse count since the last V needs a B so the V alternates.
          if (!odd_reg) begin
            p_next        = ~last_pol_reg;
            n_next        = last_pol_reg;
            last_pol_next = ~last_pol_reg;
`ifdef HDBN_VIOL_FLAG_EN
            b_next        = 1'b1;
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_reg       <= '0;
      fill_reg     <= '0;
      skip_reg     <= '0;
      last_pol_reg <= 1'b0;
      odd_reg      <= 1'b0;
      out_valid    <= 1'b0;
      out_p        <= 1'b0;
      out_n        <= 1'b0;
`ifdef HDBN_VIOL_FLAG_EN
      out_v        <= 1'b0;
      out_b        <= 1'b0;
`endif
    end else begin
      sr_reg       <= sr_next;
      fill_reg     <= fill_next;
      skip_reg     <= skip_next;
      last_pol_reg <= last_pol_next;
      odd_reg      <= odd_next;
      out_valid    <= valid_next;
      out_p        <= p_next;
      out_n        <= n_next;
`ifdef HDBN_VIOL_FLAG_EN
      out_v        <= v_next;
      out_b        <= b_next;
`endif
    end
  end

endmodule

// File: tb/tb_hdbn_enc.sv
// Scoreboard bench for hdbn_enc: group-level HDB-N reference model, randomized strobed stimulus.
module tb_hdbn_enc;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, data_in = 1'b0, ami_mode = 1'b0;
  logic out_valid, out_p, out_n;
  logic ov5, op5, on5;
`ifdef HDBN_VIOL_FLAG_EN
  logic out_v, out_b, ovf5, obf5;
`endif

  always #5 clk = ~clk;

  hdbn_enc #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .ami_mode(ami_mode),
    .out_valid(out_valid), .out_p(out_p), .out_n(out_n)
`ifdef HDBN_VIOL_FLAG_EN
    , .out_v(out_v), .out_b(out_b)
`endif
  );

  hdbn_enc #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .ami_mode(ami_mode),
    .out_valid(ov5), .out_p(op5), .out_n(on5)
`ifdef HDBN_VIOL_FLAG_EN
    , .out_v(ovf5), .out_b(obf5)
`endif
  );

  typedef struct packed {logic p; logic n; logic v; logic b;} sym_t;

  int n_pass = 0;
  int n_total = 0;
  bit   bits_q[$];
  sym_t plan_q[$];
  sym_t exp_q[$];
  logic [1:0] seen_q[$];
  logic [1:0] seen5_q[$];
  logic [1:0] want_q[$];
  int marks = 0;
  int last = -1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
  endtask

  function automatic sym_t mk(input int pol, input logic v, input logic b);
    sym_t s;
    s.p = (pol > 0);
    s.n = (pol < 0);
    s.v = v;
    s.b = b;
    return s;
  endfunction

  // Reference: textbook HDB-N on the accepted bit sequence, whole groups planned at once.
  task automatic model_accept(input logic d, input logic a);
    sym_t s;
    bit allz;
    bits_q.push_back(d);
    if (bits_q.size() == N + 2) begin
      if (plan_q.size() > 0) begin
        s = plan_q.pop_front();
      end else if (bits_q[0]) begin
        last = -last;
        marks++;
        s = mk(last, 1'b0, 1'b0);
      end else begin
        allz = 1'b1;
        for (int i = 0; i <= N; i++) if (bits_q[i]) allz = 1'b0;
        if (!a && allz) begin
          if (marks % 2 == 0) begin
            last = -last;
            s = mk(last, 1'b0, 1'b1);
          end else begin
            s = mk(0, 1'b0, 1'b0);
          end
          for (int i = 1; i < N; i++) plan_q.push_back(mk(0, 1'b0, 1'b0));
          plan_q.push_back(mk(last, 1'b1, 1'b0));
          marks = 0;
        end else begin
          s = mk(0, 1'b0, 1'b0);
        end
      end
      void'(bits_q.pop_front());
      exp_q.push_back(s);
    end
  endtask

  task automatic model_clear();
    bits_q.delete();
    plan_q.delete();
    exp_q.delete();
    marks = 0;
    last = -1;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic drive(input logic v, input logic d, input logic a);
    in_valid = v;
    data_in  = d;
    ami_mode = a;
    @(posedge clk);
    if (v && !rst) model_accept(d, a);
    #1;
  endtask

  task automatic do_reset(input bit check_now);
    in_valid = 1'b0;
    rst = 1'b1;
    model_clear();
    #1;
    if (check_now) chk("async_reset_outputs", {5'b0, out_valid, out_p, out_n}, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic compare_seen(input string name, input bit use5);
    int sz;
    sz = use5 ? seen5_q.size() : seen_q.size();
    chk({name, "_count"}, 8'(sz), 8'(want_q.size()));
    for (int i = 0; i < want_q.size() && i < sz; i++)
      chk({name, "_sym"}, {6'b0, use5 ? seen5_q[i] : seen_q[i]}, {6'b0, want_q[i]});
  endtask

  // Monitor: every negedge, out_valid must match whether a symbol is due.
  always @(negedge clk) begin
    sym_t e;
    logic due;
    logic [3:0] act;
    due = (exp_q.size() > 0);
`ifdef HDBN_VIOL_FLAG_EN
    act = {out_p, out_n, out_v, out_b};
`else
    act = {out_p, out_n, 2'b00};
`endif
    chk("out_valid", {7'b0, out_valid}, {7'b0, due});
    if (due) begin
      e = exp_q.pop_front();
`ifndef HDBN_VIOL_FLAG_EN
      e.v = 1'b0;
      e.b = 1'b0;
`endif
      if (out_valid) begin
        chk("symbol", {4'b0, act}, {4'b0, e});
        $display("t=%0t symbol p=%0b n=%0b v=%0b b=%0b expected %0b%0b%0b%0b",
                 $time, act[3], act[2], act[1], act[0], e.p, e.n, e.v, e.b);
      end
    end else if (!out_valid) begin
      chk("idle_outputs", {4'b0, act}, 8'h00);
    end
    if (out_valid) seen_q.push_back({out_p, out_n});
    if (ov5) seen5_q.push_back({op5, on5});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v, d, a;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill phase: three accepts, no symbol.
    seen_q.delete();
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("fill_quiet", 8'(seen_q.size()), 8'd0);

    // B00V path with even parity.
    do_reset(1'b0);
    seen_q.delete();
    foreach (want_q[i]) ;
    want_q = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
    drive(1, 0, 0); drive(1, 0, 0); drive(1, 0, 0); drive(1, 0, 0);
    drive(1, 1, 0); drive(1, 1, 0);
    repeat (4) drive(1, 0, 0);
    drive(0, 0, 0);
    compare_seen("b00v", 1'b0);

    // 000V path with odd parity.
    do_reset(1'b0);
    seen_q.delete();
    want_q = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
    drive(1, 1, 0); drive(1, 0, 0); drive(1, 0, 0); drive(1, 0, 0);
    drive(1, 0, 0); drive(1, 1, 0);
    repeat (4) drive(1, 0, 0);
    drive(0, 0, 0);
    compare_seen("000v", 1'b0);

    // Plain AMI: zeros pass through untouched.
    do_reset(1'b0);
    seen_q.delete();
    want_q = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    drive(1, 1, 1);
    repeat (6) drive(1, 0, 1);
    drive(1, 1, 1);
    repeat (4) drive(1, 0, 1);
    drive(0, 0, 0);
    compare_seen("ami", 1'b0);

    // N=5 instance: six zeros give B+,0,0,0,0,V+.
    do_reset(1'b0);
    seen5_q.delete();
    want_q = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    repeat (12) drive(1, 0, 0);
    drive(0, 0, 0);
    compare_seen("n5", 1'b1);

    // Strobe every third cycle, reset in the middle of a group.
    do_reset(1'b0);
    seen_q.delete();
    want_q = '{2'b10, 2'b00};
    repeat (6) begin
      drive(1, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
    end
    compare_seen("strobed_pre_reset", 1'b0);
    do_reset(1'b1);
    seen_q.delete();
    repeat (4) begin
      drive(1, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
    end
    chk("post_reset_quiet", 8'(seen_q.size()), 8'd0);
    repeat (8) begin
      drive(1, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
    end

    // Randomized traffic with sparse ones, gaps and occasional mode changes.
    a = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if (i == 350) do_reset(1'b1);
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 63) == 0) a = ~a;
      drive(v, d, a);
    end
    repeat (3) drive(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
